shmem_rx_packet_writer: RTL and testbench

//  Receive-side DMA stage feeding port 2 of the 1024x32 dual-port Nios shared memory.

---
 rtl/shmem_rx_pkg.sv | 30 +++
 rtl/shmem_byte_packer.sv | 70 +++++++
 rtl/shmem_rx_packet_writer.sv | 181 ++++++++++++++++++
 tb/tb_shmem_rx_packet_writer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shmem_rx_pkg.sv
// Shared constants, FSM state encodings and header packing for the receive-side
// shared-memory packet writer.
package shmem_rx_pkg;

  localparam int HDR_FULL_BIT  = 31;
  localparam int HDR_TRUNC_BIT = 30;
  localparam int HDR_LEN_MSB   = 15;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_HDR  = 3'd1;
  localparam state_t ST_CHK_HDR = 3'd2;
  localparam state_t ST_PAYLOAD = 3'd3;
  localparam state_t ST_FLUSH   = 3'd4;
  localparam state_t ST_WR_HDR  = 3'd5;
  localparam state_t ST_DROP    = 3'd6;

  // A published header always carries FULL=1; the Nios clears it to hand the slot back.
  function automatic logic [31:0] pack_header(input logic trunc,
                                              input logic [HDR_LEN_MSB:0] len);
    logic [31:0] hdr;
    hdr                  = '0;
    hdr[HDR_FULL_BIT]    = 1'b1;
    hdr[HDR_TRUNC_BIT]   = trunc;
    hdr[HDR_LEN_MSB:0]   = len;
    return hdr;
  endfunction

endpackage

// File: rtl/shmem_byte_packer.sv
// Little-endian byte-to-word accumulator; emits one registered word (with lane mask)
// when lane 3 fills or the packet's last byte arrives.
module shmem_byte_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  lane_i,
  input  logic        last_i,
  output logic        word_valid_o,
  output logic [31:0] word_o,
  output logic [3:0]  be_o
);

  logic [31:0] acc_q, acc_d;
  logic [3:0]  mask_q, mask_d;
  logic        word_valid_q, word_valid_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] merged;
  logic [3:0]  merged_mask;

  always_comb begin
    acc_d        = acc_q;
    mask_d       = mask_q;
    word_valid_d = 1'b0;
    word_d       = word_q;
    be_d         = be_q;
    merged       = acc_q;
    merged_mask  = mask_q | (4'b0001 << lane_i);
    merged[{lane_i, 3'b000} +: 8] = byte_i;
    if (clear_i) begin
      acc_d  = '0;
      mask_d = '0;
    end else if (byte_valid_i) begin
      if (lane_i == 2'd3 || last_i) begin
        word_valid_d = 1'b1;
        word_d       = merged;
        be_d         = merged_mask;
        acc_d        = '0;
        mask_d       = '0;
      end else begin
        acc_d  = merged;
        mask_d = merged_mask;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q        <= '0;
      mask_q       <= '0;
      word_valid_q <= 1'b0;
      word_q       <= '0;
      be_q         <= '0;
    end else begin
      acc_q        <= acc_d;
      mask_q       <= mask_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
      be_q         <= be_d;
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;
  assign be_o         = be_q;

endmodule

// File: rtl/shmem_rx_packet_writer.sv
// Receive DMA stage: writes byte-stream packets into a ring of shared-memory slots,
// publishes a header per slot and pulses irq for the Nios.
module shmem_rx_packet_writer
  import shmem_rx_pkg::*;
#(
  parameter int BASE_ADDR  = 0,
  parameter int SLOT_WORDS = 128,
  parameter int NUM_SLOTS  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  output logic [9:0]  mem_address,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  output logic        mem_clken,
  output logic        irq,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count
);

  localparam int          SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [15:0] CAP    = 16'((SLOT_WORDS - 1) * 4);

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                trunc_q, trunc_d;
  logic [9:0]          wr_addr_q, wr_addr_d;
  logic                irq_q, irq_d;
  logic [15:0]         pkt_q, pkt_d;
  logic [15:0]         drop_q, drop_d;

  logic [9:0]  slot_base;
  logic        store;
  logic        word_valid;
  logic [31:0] word;
  logic [3:0]  word_be;
  logic        unused_rdata;

  assign slot_base    = 10'(BASE_ADDR + int'(slot_q) * SLOT_WORDS);
  assign store        = (state_q == ST_PAYLOAD) && in_valid && (cnt_q < CAP);
  assign unused_rdata = ^mem_readdata[30:0];

  shmem_byte_packer u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (state_q == ST_CHK_HDR),
    .byte_valid_i (store),
    .byte_i       (in_data),
    .lane_i       (cnt_q[1:0]),
    .last_i       (in_eop),
    .word_valid_o (word_valid),
    .word_o       (word),
    .be_o         (word_be)
  );

  // In IDLE the sop byte is held back while the slot header is checked.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE:             in_ready = ~(in_valid & in_sop & enable);
      ST_PAYLOAD, ST_DROP: in_ready = 1'b1;
      default:             in_ready = 1'b0;
    endcase
    in_ready = in_ready & reset_n;
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    trunc_d   = trunc_q;
    wr_addr_d = wr_addr_q;
    irq_d     = 1'b0;
    pkt_d     = pkt_q;
    drop_d    = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_sop && enable) state_d = ST_RD_HDR;
      end
      ST_RD_HDR: state_d = ST_CHK_HDR;
      ST_CHK_HDR: begin
        if (mem_readdata[HDR_FULL_BIT]) begin
          state_d = ST_DROP;
        end else begin
          state_d = ST_PAYLOAD;
          cnt_d   = '0;
          trunc_d = 1'b0;
        end
      end
      ST_PAYLOAD: begin
        if (in_valid) begin
          if (cnt_q < CAP) begin
            cnt_d     = cnt_q + 16'd1;
            wr_addr_d = 10'(int'(slot_base) + 1 + int'(cnt_q[15:2]));
          end else begin
            trunc_d = 1'b1;
          end
          if (in_eop) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_WR_HDR;
      ST_WR_HDR: begin
        irq_d   = 1'b1;
        pkt_d   = pkt_q + 16'd1;
        slot_d  = (slot_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_q + 1'b1;
        state_d = ST_IDLE;
      end
      ST_DROP: begin
        if (in_valid && in_eop) begin
          drop_d  = drop_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Payload writes come from the packer one cycle after the word completes, so the
  // last one always lands in FLUSH, before the header write in WR_HDR.
  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (state_q == ST_RD_HDR) begin
      mem_chipselect = 1'b1;
      mem_address    = slot_base;
    end else if (word_valid) begin
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
      mem_address    = wr_addr_q;
      mem_byteenable = word_be;
      mem_writedata  = word;
    end else if (state_q == ST_WR_HDR) begin
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
      mem_address    = slot_base;
      mem_byteenable = 4'hF;
      mem_writedata  = pack_header(trunc_q, cnt_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      slot_q    <= '0;
      cnt_q     <= '0;
      trunc_q   <= 1'b0;
      wr_addr_q <= '0;
      irq_q     <= 1'b0;
      pkt_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      trunc_q   <= trunc_d;
      wr_addr_q <= wr_addr_d;
      irq_q     <= irq_d;
      pkt_q     <= pkt_d;
      drop_q    <= drop_d;
    end
  end

  assign mem_clken  = 1'b1;
  assign irq        = irq_q;
  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_shmem_rx_packet_writer.sv
// Bench for shmem_rx_packet_writer: shared-memory model on port 2 plus a write
// scoreboard filled as packets are driven and drained as the DUT writes.
module tb_shmem_rx_packet_writer;

  localparam int SW  = 128;
  localparam int NS  = 8;
  localparam int CAP = (SW - 1) * 4;

  typedef struct {
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  in_data;
  logic        in_valid, in_sop, in_eop;
  logic        in_ready;
  logic [9:0]  mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;
  logic        irq;
  logic [15:0] pkt_count, drop_count;

  logic [31:0] shmem [1024];
  logic        bench_wr;
  logic [9:0]  bench_addr;
  logic [31:0] bench_data;
  logic        auto_rel;
  int          rel_slot;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  irq_count = 0;
  int  wr_count = 0;
  bit  irq_prev = 0;
  bit  last_acc = 0;
  int  exp_pkt, exp_drop;

  always #5 clk = ~clk;

  shmem_rx_packet_writer #(.BASE_ADDR(0), .SLOT_WORDS(SW), .NUM_SLOTS(NS)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .in_ready       (in_ready),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .mem_clken      (mem_clken),
    .irq            (irq),
    .pkt_count      (pkt_count),
    .drop_count     (drop_count)
  );

  // Shared memory port 2 model, plus the Nios side (bench writes and auto-release on irq).
  always @(posedge clk) begin
    if (mem_chipselect && !mem_write) mem_readdata <= shmem[mem_address];
    if (mem_chipselect && mem_write) begin
      for (int l = 0; l < 4; l++)
        if (mem_byteenable[l]) shmem[mem_address][8*l +: 8] <= mem_writedata[8*l +: 8];
    end else if (bench_wr) begin
      shmem[bench_addr] <= bench_data;
    end
    if (!reset_n) begin
      rel_slot <= 0;
    end else if (irq && auto_rel) begin
      shmem[10'(rel_slot * SW)][31] <= 1'b0;
      rel_slot <= (rel_slot + 1) % NS;
    end
  end

  // Advance one cycle, observing outputs on the falling edge.
  task automatic step();
    wr_t         e;
    logic [31:0] m;
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (irq) begin
      irq_count++;
      checks++;
      if (irq_prev) begin
        errors++;
        $display("[TB] FAIL irq_width: irq high %0d cycles in a row, required 1", 2);
      end
    end
    irq_prev = irq;
    if (mem_write) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: addr=%0d be=%h data=%h, required no write",
                 mem_address, mem_byteenable, mem_writedata);
      end else begin
        e = exp_q.pop_front();
        for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{e.be[l]}};
        if (mem_address !== e.addr || mem_byteenable !== e.be ||
            (mem_writedata & m) !== e.data || mem_chipselect !== 1'b1) begin
          errors++;
          $display("[TB] FAIL write: addr=%0d be=%h data=%h cs=%b, required addr=%0d be=%h data=%h cs=1",
                   mem_address, mem_byteenable, mem_writedata & m, mem_chipselect,
                   e.addr, e.be, e.data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bench_write(input int addr, input logic [31:0] data);
    bench_addr = 10'(addr);
    bench_data = data;
    bench_wr   = 1'b1;
    step();
    bench_wr   = 1'b0;
  endtask

  task automatic nios_release(input int slot);
    bench_write(slot * SW, shmem[10'(slot * SW)] & 32'h7FFF_FFFF);
  endtask

  // Expected writes for a packet of len bytes (byte n = seed+n) into a free slot.
  task automatic push_packet(input int slot, input int len, input logic [7:0] seed, input bit with_hdr);
    int  stored;
    wr_t e;
    stored = (len < CAP) ? len : CAP;
    for (int w = 0; w < (stored + 3) / 4; w++) begin
      e.addr = 10'(slot * SW + 1 + w);
      e.be   = '0;
      e.data = '0;
      for (int l = 0; l < 4; l++) begin
        if (w * 4 + l < stored) begin
          e.be[l]          = 1'b1;
          e.data[8*l +: 8] = 8'(int'(seed) + w * 4 + l);
        end
      end
      exp_q.push_back(e);
    end
    if (with_hdr) begin
      e.addr = 10'(slot * SW);
      e.be   = 4'hF;
      e.data = {1'b1, (len > CAP), 14'b0, 16'(stored)};
      exp_q.push_back(e);
    end
  endtask

  task automatic send_packet(input int len, input logic [7:0] seed, input bit with_eop, output int acc);
    int c;
    acc = 0;
    for (int n = 0; n < len; n++) begin
      in_valid = 1'b1;
      in_data  = 8'(int'(seed) + n);
      in_sop   = (n == 0);
      in_eop   = with_eop && (n == len - 1);
      c = 0;
      do begin
        step();
        c++;
      end while (!last_acc && c < 20);
      if (!last_acc) begin
        checks++;
        errors++;
        $display("[TB] FAIL byte_accept: byte %0d not accepted in %0d cycles, required accept", n, c);
        break;
      end
      acc++;
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d writes outstanding, required 0", exp_q.size());
    end
    step();
    step();
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();
    reset_n  = 1'b1;
    exp_q.delete();
    exp_pkt  = 0;
    exp_drop = 0;
    step();
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata,
         irq, pkt_count, drop_count} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: ready=%b cs=%b we=%b addr=%0d irq=%b pkt=%0d drop=%0d, required all 0",
               in_ready, mem_chipselect, mem_write, mem_address, irq, pkt_count, drop_count);
    end
    checks++;
    if (mem_clken !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_clken: %b, required 1", mem_clken);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_ready: %b, required 1", in_ready);
    end
    in_valid = 1'b1;
    in_sop   = 1'b1;
    enable   = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_ready_disabled: %b, required 1", in_ready);
    end
    enable = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_hold_sop: %b, required 0", in_ready);
    end
    in_sop = 1'b0;
    repeat (3) step();
    in_valid = 1'b0;
    step();
    checks++;
    if (mem_chipselect !== 1'b0) begin
      errors++;
      $display("[TB] FAIL non_sop_discard: cs=%b, required 0", mem_chipselect);
    end
  endtask

  task automatic test_six_byte();
    int acc, irq0;
    irq0 = irq_count;
    push_packet(0, 6, 8'h01, 1);
    send_packet(6, 8'h01, 1, acc);
    wait_done(50);
    exp_pkt++;
    checks++;
    if (irq_count - irq0 != 1 || acc != 6) begin
      errors++;
      $display("[TB] FAIL six_irq_acc: irqs=%0d accepted=%0d, required 1 and 6", irq_count - irq0, acc);
    end
    checks++;
    if (shmem[0] !== 32'h8000_0006 || shmem[1] !== 32'h0403_0201 || shmem[2][15:0] !== 16'h0605) begin
      errors++;
      $display("[TB] FAIL six_mem: hdr=%h w1=%h w2=%h, required 80000006 04030201 xxxx0605",
               shmem[0], shmem[1], shmem[2]);
    end
    checks++;
    if (pkt_count !== 16'(exp_pkt)) begin
      errors++;
      $display("[TB] FAIL six_pkt_count: %0d, required %0d", pkt_count, exp_pkt);
    end
    nios_release(0);
  endtask

  task automatic test_drop();
    int acc, irq0, wr0;
    bench_write(1 * SW, 32'h8000_0010);
    irq0 = irq_count;
    wr0  = wr_count;
    send_packet(20, 8'h30, 1, acc);
    repeat (5) step();
    exp_drop++;
    checks++;
    if (drop_count !== 16'(exp_drop) || acc != 20) begin
      errors++;
      $display("[TB] FAIL drop_count: %0d accepted=%0d, required %0d and 20", drop_count, acc, exp_drop);
    end
    checks++;
    if (irq_count != irq0 || wr_count != wr0 || shmem[SW] !== 32'h8000_0010) begin
      errors++;
      $display("[TB] FAIL drop_quiet: irqs=%0d writes=%0d hdr=%h, required 0 0 80000010",
               irq_count - irq0, wr_count - wr0, shmem[SW]);
    end
    nios_release(1);
  endtask

  task automatic test_one_byte();
    int acc;
    push_packet(1, 1, 8'hAA, 1);
    send_packet(1, 8'hAA, 1, acc);
    wait_done(50);
    exp_pkt++;
    checks++;
    if (shmem[SW] !== 32'h8000_0001 || shmem[SW + 1][7:0] !== 8'hAA || pkt_count !== 16'(exp_pkt)) begin
      errors++;
      $display("[TB] FAIL one_byte: hdr=%h lane0=%h pkt=%0d, required 80000001 aa %0d",
               shmem[SW], shmem[SW + 1][7:0], pkt_count, exp_pkt);
    end
    nios_release(1);
  endtask

  task automatic test_truncate();
    int acc, wr0;
    wr0 = wr_count;
    push_packet(2, 600, 8'h10, 1);
    send_packet(600, 8'h10, 1, acc);
    wait_done(100);
    exp_pkt++;
    checks++;
    if (acc != 600 || wr_count - wr0 != 128) begin
      errors++;
      $display("[TB] FAIL trunc_counts: accepted=%0d writes=%0d, required 600 and 128", acc, wr_count - wr0);
    end
    checks++;
    if (shmem[2 * SW] !== 32'hC000_01FC || shmem[2 * SW + 127] !== 32'h0B0A_0908) begin
      errors++;
      $display("[TB] FAIL trunc_mem: hdr=%h last=%h, required c00001fc 0b0a0908",
               shmem[2 * SW], shmem[2 * SW + 127]);
    end
    nios_release(2);
  endtask

  task automatic test_mid_reset();
    int acc;
    push_packet(3, 4, 8'h60, 0);
    send_packet(5, 8'h60, 0, acc);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata,
         irq, pkt_count, drop_count} !== '0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: ready=%b cs=%b we=%b pkt=%0d pending=%0d, required all 0",
               in_ready, mem_chipselect, mem_write, pkt_count, exp_q.size());
    end
    repeat (3) step();
    checks++;
    if (shmem[3 * SW] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_hdr: %h, required 00000000", shmem[3 * SW]);
    end
    reset_n  = 1'b1;
    exp_pkt  = 0;
    exp_drop = 0;
    step();
    push_packet(0, 4, 8'h70, 1);
    send_packet(4, 8'h70, 1, acc);
    wait_done(50);
    exp_pkt++;
    checks++;
    if (shmem[0] !== 32'h8000_0004 || pkt_count !== 16'(exp_pkt)) begin
      errors++;
      $display("[TB] FAIL restart_slot0: hdr=%h pkt=%0d, required 80000004 %0d", shmem[0], pkt_count, exp_pkt);
    end
    nios_release(0);
  endtask

  task automatic test_back_to_back();
    int acc, irq0;
    apply_reset();
    auto_rel = 1'b1;
    irq0 = irq_count;
    for (int i = 0; i < 9; i++) begin
      push_packet(i % NS, 5 + i, 8'(i * 16), 1);
      send_packet(5 + i, 8'(i * 16), 1, acc);
      exp_pkt++;
    end
    wait_done(100);
    checks++;
    if (pkt_count !== 16'(exp_pkt) || irq_count - irq0 != 9) begin
      errors++;
      $display("[TB] FAIL b2b_counts: pkt=%0d irqs=%0d, required %0d and 9", pkt_count, irq_count - irq0, exp_pkt);
    end
    checks++;
    if ((shmem[0] & 32'h7FFF_FFFF) !== 32'h0000_000D) begin
      errors++;
      $display("[TB] FAIL b2b_wrap: slot0 hdr=%h, required len 0000000d", shmem[0]);
    end
    auto_rel = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    bench_wr = 1'b0;
    bench_addr = '0;
    bench_data = '0;
    auto_rel = 1'b0;
    exp_pkt  = 0;
    exp_drop = 0;
    for (int s = 0; s < NS; s++) bench_write(s * SW, 32'h0);
    test_reset();
    test_six_byte();
    test_drop();
    test_one_byte();
    test_truncate();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
